// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle MIPS datapath.
// Radix-2 Booth multiply and restoring divide, one step per clock, HI/LO results.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ITER_BITS  = 5
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  MultCtrl,
  input  logic                  DivCtrl,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivZero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned AW = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t               state;
  logic [ITER_BITS-1:0] cnt;
  logic [W-1:0]         mcand;
  logic [AW-1:0]        acc;
  logic [W-1:0]         dvs;
  logic [W-1:0]         rem;
  logic [W-1:0]         quo;
  logic                 neg_q;
  logic                 neg_r;
  logic                 zero_flag;

  logic                 last_step;
  logic [W:0]           booth_sum;
  logic [AW-1:0]        acc_next;
  logic [W:0]           trial;
  logic [W-1:0]         rem_next;
  logic [W-1:0]         quo_next;
  logic [W-1:0]         div_hi;
  logic [W-1:0]         div_lo;
  logic [W-1:0]         a_mag;
  logic [W-1:0]         b_mag;

  assign last_step = (cnt == ITER_BITS'(DATA_WIDTH - 1));
  assign a_mag     = A[W-1] ? (W'(0) - A) : A;
  assign b_mag     = B[W-1] ? (W'(0) - B) : B;

  // Booth step: the upper half is summed one bit wider so that -(-2^(W-1)) cannot overflow
  always_comb begin
    booth_sum = {acc[AW-1], acc[AW-1 -: W]};
    case (acc[1:0])
      2'b01:   booth_sum = {acc[AW-1], acc[AW-1 -: W]} + {mcand[W-1], mcand};
      2'b10:   booth_sum = {acc[AW-1], acc[AW-1 -: W]} - {mcand[W-1], mcand};
      default: booth_sum = {acc[AW-1], acc[AW-1 -: W]};
    endcase
    acc_next = {booth_sum, acc[W:1]};
  end

  // Restoring divide step on magnitudes, then sign fix-up of the final values
  always_comb begin
    trial = {rem, quo[W-1]} - {1'b0, dvs};
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = {rem[W-2:0], quo[W-1]};
      quo_next = {quo[W-2:0], 1'b0};
    end
    div_lo = neg_q ? (W'(0) - quo_next) : quo_next;
    div_hi = neg_r ? (W'(0) - rem_next) : rem_next;
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_flag <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (MultCtrl) begin
            mcand     <= A;
            acc       <= {W'(0), B, 1'b0};
            cnt       <= '0;
            zero_flag <= 1'b0;
            Busy      <= 1'b1;
            state     <= MULT;
          end else if (DivCtrl) begin
            if (B != W'(0)) begin
              dvs       <= b_mag;
              quo       <= a_mag;
              rem       <= '0;
              neg_q     <= A[W-1] ^ B[W-1];
              neg_r     <= A[W-1];
              cnt       <= '0;
              zero_flag <= 1'b0;
              Busy      <= 1'b1;
              state     <= DIV;
            end else begin
              zero_flag <= 1'b1;
              state     <= FINISH;
            end
          end
        end
        MULT: begin
          acc <= acc_next;
          cnt <= cnt + ITER_BITS'(1);
          if (last_step) begin
            HI    <= acc_next[AW-1 -: W];
            LO    <= acc_next[W:1];
            Busy  <= 1'b0;
            state <= FINISH;
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + ITER_BITS'(1);
          if (last_step) begin
            HI    <= div_hi;
            LO    <= div_lo;
            Busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
          Done      <= 1'b1;
          DivZero   <= zero_flag;
          zero_flag <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random mult/div
// compared against plain 64-bit signed arithmetic.
module tb_mult_div_unit;

  logic        clock;
  logic        Reset;
  logic        MultCtrl;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi = 32'h0;
  logic [31:0] ref_lo = 32'h0;

  mult_div_unit #(.DATA_WIDTH(32), .ITER_BITS(5)) dut (
    .clock(clock), .Reset(Reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
    .A(A), .B(B), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint qa, qb, q, r;
    logic [63:0] qv, rv;
    qa = longint'($signed(a));
    qb = longint'($signed(b));
    q  = qa / qb;
    r  = qa % qb;
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction

  // Drive one start pulse for a single edge; operands are scrambled right after it
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    MultCtrl = m; DivCtrl = d; A = a; B = b;
    @(posedge clock);
    #1;
    MultCtrl = 1'b0; DivCtrl = 1'b0; A = $urandom; B = $urandom;
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input string tag);
    logic [63:0] res;
    logic [31:0] eh, el;
    bit edz;
    int exp_lat, exp_busy, n, busy_cnt;
    if (m) begin
      res = ref_mul(a, b); eh = res[63:32]; el = res[31:0];
      edz = 1'b0; exp_lat = 33; exp_busy = 32;
    end else if (b == 32'h0) begin
      eh = ref_hi; el = ref_lo; edz = 1'b1; exp_lat = 1; exp_busy = 0;
    end else begin
      res = ref_div(a, b); eh = res[63:32]; el = res[31:0];
      edz = 1'b0; exp_lat = 33; exp_busy = 32;
    end
    start_op(m, d, a, b);
    n = 0;
    busy_cnt = Busy ? 1 : 0;
    while (n < 100) begin
      if (inject) begin
        if (n == 9)  DivCtrl = 1'b1;
        if (n == 10) DivCtrl = 1'b0;
        if (n == 19) begin MultCtrl = 1'b1; DivCtrl = 1'b1; end
        if (n == 20) begin MultCtrl = 1'b0; DivCtrl = 1'b0; end
        if (n == 32) MultCtrl = 1'b1;
      end
      @(posedge clock);
      #1;
      n++;
      if (inject && n == 33) MultCtrl = 1'b0;
      if (Done) break;
      if (Busy) busy_cnt++;
    end
    MultCtrl = 1'b0; DivCtrl = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " HI"}, HI, eh);
    check({tag, " LO"}, LO, el);
    check({tag, " DivZero"}, 32'(DivZero), 32'(edz));
    check({tag, " busy_at_done"}, 32'(Busy), 32'h0);
    @(posedge clock);
    #1;
    check({tag, " done_single"}, 32'(Done), 32'h0);
    check({tag, " divzero_single"}, 32'(DivZero), 32'h0);
    check({tag, " idle_busy"}, 32'(Busy), 32'h0);
    check({tag, " HI_hold"}, HI, eh);
    check({tag, " LO_hold"}, LO, el);
    ref_hi = eh;
    ref_lo = el;
  endtask

  initial begin
    logic [31:0] ra, rb;
    int done_seen;
    Reset = 1'b1; MultCtrl = 1'b0; DivCtrl = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset HI", HI, 32'h0);
    check("reset LO", LO, 32'h0);
    check("reset ctl", {29'h0, Busy, Done, DivZero}, 32'h0);
    @(negedge clock);
    Reset = 1'b0;
    @(posedge clock);
    #1;
    check("post-reset ctl", {29'h0, Busy, Done, DivZero}, 32'h0);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, "mul7x-3");
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, "mulmin2");
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulm1m1");
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, "div-7/2");
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, "div100/7");
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, "divmin/-1");
    run_op(1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, "preload");
    run_op(1'b0, 1'b1, 32'h55555555, 32'h0, 1'b0, "div0");
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b1, "ignore_starts");
    run_op(1'b1, 1'b1, 32'd1000, 32'd3, 1'b0, "both_start");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(0, 15)) - 32'd8;
      run_op(1'b1, 1'b0, ra, rb, 1'b0, "rnd_mul");
      ra = $urandom; rb = $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(1, 300));
      if (i % 5 == 2) rb = 32'h0 - 32'($urandom_range(1, 300));
      run_op(1'b0, 1'b1, ra, rb, 1'b0, "rnd_div");
    end

    // Asynchronous reset in the middle of a multiply
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    repeat (15) @(posedge clock);
    #2;
    Reset = 1'b1;
    #1;
    check("abort HI", HI, 32'h0);
    check("abort LO", LO, 32'h0);
    check("abort ctl", {29'h0, Busy, Done, DivZero}, 32'h0);
    ref_hi = 32'h0;
    ref_lo = 32'h0;
    @(negedge clock);
    Reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (Done || Busy) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'h0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
